// File: rtl/draw_background_pattern_if.sv
// draw_background_pattern_if: VGA timing bundle (counts, syncs, blanks) passed between draw stages.
interface draw_background_pattern_if #(
    parameter int CNT_W = 11
);
    logic [CNT_W-1:0] vcount;
    logic [CNT_W-1:0] hcount;
    logic             vsync;
    logic             vblnk;
    logic             hsync;
    logic             hblnk;
    modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk);
    modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk);
endinterface

// File: rtl/draw_background_pattern.sv
// draw_background_pattern: runtime-selectable background colour with frame-shadowed settings,
// scrolling checkerboard and a 2-cycle timing pass-through.
module draw_background_pattern #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int CNT_W      = 11,
    parameter int RGB_W      = 12,
    parameter int CHECK_LOG2 = 5,
    parameter int BAR_LOG2   = 7
) (
    input  logic                       pclk,
    input  logic                       reset_n,
    input  logic [1:0]                 mode_in,
    input  logic [RGB_W-1:0]           fg_in,
    input  logic [RGB_W-1:0]           bg_in,
    draw_background_pattern_if.slave   timing_in,
    draw_background_pattern_if.master  timing_out,
    output logic [RGB_W-1:0]           rgb_out,
    output logic [7:0]                 frame_cnt
);
    localparam int F = RGB_W / 3;
    localparam logic [RGB_W-1:0] YELLOW = {{(2*F){1'b1}}, {F{1'b0}}};
    localparam logic [RGB_W-1:0] RED    = {{F{1'b1}}, {(2*F){1'b0}}};
    localparam logic [RGB_W-1:0] GREEN  = {{F{1'b0}}, {F{1'b1}}, {F{1'b0}}};
    localparam logic [RGB_W-1:0] BLUE   = {{(2*F){1'b0}}, {F{1'b1}}};
    typedef enum logic [1:0] {BORDER, SOLID, CHECKER, BARS} mode_t;
    mode_t            mode, mode_1;
    logic [RGB_W-1:0] fg, bg, fg_1, bg_1, colour;
    logic             vblnk_d, frame_start, sel;
    logic             top_1, bot_1, left_1, right_1, sel_1;
    logic [2:0]       bar_1;
    logic [CNT_W-1:0] vcount_1, hcount_1;
    logic             vsync_1, vblnk_1, hsync_1, hblnk_1;
    assign frame_start = timing_in.vblnk & ~vblnk_d;
    // the sum is kept CNT_W+1 bits wide so the scroll offset never wraps before the shift
    assign sel = 1'(({1'b0, timing_in.hcount} + (CNT_W+1)'(frame_cnt)) >> CHECK_LOG2)
               ^ 1'(timing_in.vcount >> CHECK_LOG2);
    always_ff @(posedge pclk or negedge reset_n)
        if (!reset_n) begin
            vblnk_d   <= 1'b0;
            mode      <= BORDER;
            fg        <= '1;
            bg        <= '1;
            frame_cnt <= '0;
        end else begin
            vblnk_d <= timing_in.vblnk;
            if (frame_start) begin
                mode      <= mode_t'(mode_in);
                fg        <= fg_in;
                bg        <= bg_in;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    always_ff @(posedge pclk or negedge reset_n)
        if (!reset_n) begin
            {vcount_1, hcount_1, vsync_1, vblnk_1, hsync_1, hblnk_1} <= '0;
            {top_1, bot_1, left_1, right_1, sel_1, bar_1} <= '0;
            mode_1 <= BORDER;
            fg_1   <= '0;
            bg_1   <= '0;
        end else begin
            vcount_1 <= timing_in.vcount;
            hcount_1 <= timing_in.hcount;
            vsync_1  <= timing_in.vsync;
            vblnk_1  <= timing_in.vblnk;
            hsync_1  <= timing_in.hsync;
            hblnk_1  <= timing_in.hblnk;
            mode_1   <= mode;
            fg_1     <= fg;
            bg_1     <= bg;
            top_1    <= timing_in.vcount == '0;
            bot_1    <= timing_in.vcount == CNT_W'(V_ACTIVE - 1);
            left_1   <= timing_in.hcount == '0;
            right_1  <= timing_in.hcount == CNT_W'(H_ACTIVE - 1);
            sel_1    <= sel;
            bar_1    <= timing_in.hcount[BAR_LOG2+2:BAR_LOG2];
        end
    always_comb
        colour = mode_1 == SOLID   ? bg_1 :
                 mode_1 == CHECKER ? (sel_1 ? fg_1 : bg_1) :
                 mode_1 == BARS    ? {{F{bar_1[2]}}, {F{bar_1[1]}}, {F{bar_1[0]}}} :
                 top_1 ? YELLOW : bot_1 ? RED : left_1 ? GREEN : right_1 ? BLUE : bg_1;
    always_ff @(posedge pclk or negedge reset_n)
        if (!reset_n) begin
            timing_out.vcount <= '0;
            timing_out.hcount <= '0;
            timing_out.vsync  <= 1'b0;
            timing_out.vblnk  <= 1'b0;
            timing_out.hsync  <= 1'b0;
            timing_out.hblnk  <= 1'b0;
            rgb_out           <= '0;
        end else begin
            timing_out.vcount <= vcount_1;
            timing_out.hcount <= hcount_1;
            timing_out.vsync  <= vsync_1;
            timing_out.vblnk  <= vblnk_1;
            timing_out.hsync  <= hsync_1;
            timing_out.hblnk  <= hblnk_1;
            rgb_out           <= (vblnk_1 | hblnk_1) ? '0 : colour;
        end
endmodule

// File: tb/tb_draw_background_pattern.sv
// tb_draw_background_pattern: vector tables and a 2-deep expectation queue against draw_background_pattern.
module tb_draw_background_pattern;
    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  mode_in = 2'd0;
    logic [11:0] fg_in = '0;
    logic [11:0] bg_in = '0;
    logic [11:0] rgb_out;
    logic [7:0]  frame_cnt;
    int checks = 0;
    int errors = 0;

    draw_background_pattern_if #(.CNT_W(11)) tin ();
    draw_background_pattern_if #(.CNT_W(11)) tout ();

    draw_background_pattern dut (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .mode_in   (mode_in),
        .fg_in     (fg_in),
        .bg_in     (bg_in),
        .timing_in (tin),
        .timing_out(tout),
        .rgb_out   (rgb_out),
        .frame_cnt (frame_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [10:0] h, v;
        logic        hs, vs, hb, vb, chk;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        logic [10:0] h, v;
        logic        hb;
        logic [11:0] rgb;
    } vec_t;

    exp_t q[$];
    vec_t vecs [0:24];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                        input logic chk, input logic [11:0] rgb);
        exp_t e;
        @(negedge pclk);
        if (q.size() == 2) begin
            e = q.pop_front();
            check("timing", {5'd0, tout.hcount, tout.vcount, tout.hsync, tout.vsync, tout.hblnk, tout.vblnk},
                  {5'd0, e.h, e.v, e.hs, e.vs, e.hb, e.vb});
            if (e.chk) check($sformatf("rgb(%0d,%0d)", e.h, e.v), {20'd0, rgb_out}, {20'd0, e.rgb});
        end
        e.h = h; e.v = v; e.hb = hb; e.vb = vb; e.chk = chk; e.rgb = rgb;
        e.hs = 1'($urandom);
        e.vs = 1'($urandom);
        tin.hcount = h; tin.vcount = v; tin.hblnk = hb; tin.vblnk = vb;
        tin.hsync = e.hs; tin.vsync = e.vs;
        q.push_back(e);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) step(vecs[i].h, vecs[i].v, vecs[i].hb, 1'b0, 1'b1, vecs[i].rgb);
        repeat (2) step(11'd0, 11'd0, 1'b1, 1'b0, 1'b1, 12'h000);
    endtask

    task automatic frame();
        repeat (2) step(11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 12'h000);
    endtask

    task automatic zeros(input string name);
        check(name, {tout.hcount, tout.vcount, tout.hsync, tout.vsync, tout.hblnk, tout.vblnk, rgb_out, frame_cnt},
              '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hb;
        vecs = '{
            '{11'd400, 11'd300, 1'b0, 12'hFFF}, '{11'd0,   11'd0,   1'b0, 12'hFF0},
            '{11'd10,  11'd599, 1'b0, 12'hF00}, '{11'd0,   11'd10,  1'b0, 12'h0F0},
            '{11'd799, 11'd10,  1'b0, 12'h00F}, '{11'd799, 11'd599, 1'b0, 12'hF00},
            '{11'd400, 11'd300, 1'b1, 12'h000},
            '{11'd0,   11'd0,   1'b0, 12'h0A5}, '{11'd400, 11'd300, 1'b0, 12'h0A5},
            '{11'd799, 11'd599, 1'b0, 12'h0A5}, '{11'd5,   11'd5,   1'b1, 12'h000},
            '{11'd0,   11'd0,   1'b0, 12'h00F}, '{11'd32,  11'd0,   1'b0, 12'hF00},
            '{11'd32,  11'd32,  1'b0, 12'h00F},
            '{11'd31,  11'd0,   1'b0, 12'hF00}, '{11'd0,   11'd0,   1'b0, 12'h00F},
            '{11'd0,   11'd100, 1'b0, 12'h000}, '{11'd127, 11'd100, 1'b0, 12'h000},
            '{11'd128, 11'd100, 1'b0, 12'h00F}, '{11'd384, 11'd100, 1'b0, 12'h0FF},
            '{11'd512, 11'd100, 1'b0, 12'hF00}, '{11'd640, 11'd100, 1'b0, 12'hF0F},
            '{11'd896, 11'd100, 1'b0, 12'hFFF}, '{11'd1024, 11'd100, 1'b0, 12'h000},
            '{11'd400, 11'd300, 1'b0, 12'h0A5}
        };
        {tin.hcount, tin.vcount, tin.hsync, tin.vsync, tin.hblnk, tin.vblnk} = '0;
        repeat (4) begin
            @(negedge pclk);
            zeros("reset_outputs");
            {tin.hcount, tin.vcount} = 22'($urandom);
            {tin.hsync, tin.vsync, tin.hblnk, tin.vblnk} = 4'($urandom);
        end
        @(negedge pclk);
        {tin.hblnk, tin.vblnk} = 2'b00;
        mode_in = 2'd1;
        bg_in = 12'h0A5;
        reset_n = 1'b1;
        run(0, 6);
        check("fc_no_frame", {24'd0, frame_cnt}, 32'd0);
        frame();
        check("fc_first_frame", {24'd0, frame_cnt}, 32'd1);
        run(7, 10);
        for (int f = 0; f < 254; f++) begin
            frame();
            repeat (2) begin
                hb = 1'($urandom);
                step(11'($urandom), 11'($urandom), hb, 1'b0, 1'b1, hb ? 12'h000 : 12'h0A5);
            end
        end
        check("fc_255", {24'd0, frame_cnt}, 32'd255);
        mode_in = 2'd2;
        fg_in = 12'hF00;
        bg_in = 12'h00F;
        frame();
        check("fc_wrap", {24'd0, frame_cnt}, 32'd0);
        run(11, 13);
        frame();
        run(14, 15);
        mode_in = 2'd3;
        frame();
        check("fc_bars", {24'd0, frame_cnt}, 32'd2);
        run(16, 23);
        @(negedge pclk);
        #2;
        reset_n = 1'b0;
        tin.vblnk = 1'b1;
        mode_in = 2'd1;
        bg_in = 12'h0A5;
        #1;
        zeros("async_reset");
        q.delete();
        repeat (2) @(negedge pclk);
        reset_n = 1'b1;
        step(11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 12'h000);
        step(11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 12'h000);
        check("fc_vblnk_after_reset", {24'd0, frame_cnt}, 32'd1);
        run(24, 24);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
